// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter : round-robin arbiter sharing one 512x32 single-port memory
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [8:0]  f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;
  localparam logic [1:0] c_S_ACK   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_gnt_data;
  logic        r_we;
  logic        r_last_data;
  logic [8:0]  r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_f_rdata;
  logic [31:0] r_d_rdata;

  logic        w_any_req;
  logic        w_pick_data;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_f_ack;
  logic        w_d_ack;
  logic        w_busy;

  assign w_any_req   = f_req | d_req;
  // On a tie the data port wins only if fetch was granted last.
  assign w_pick_data = d_req & (~f_req | ~r_last_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:  if (w_any_req) w_next_state = c_S_ISSUE;
      c_S_ISSUE: w_next_state = r_we ? c_S_ACK : c_S_WAIT;
      c_S_WAIT:  w_next_state = c_S_ACK;
      c_S_ACK:   w_next_state = c_S_IDLE;
      default:   w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_f_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_busy      = (r_state != c_S_IDLE);
    case (r_state)
      c_S_ISSUE: begin
        w_mem_read  = ~r_we;
        w_mem_write = r_we;
      end
      c_S_ACK: begin
        w_f_ack = ~r_gnt_data;
        w_d_ack = r_gnt_data;
      end
      default: ;
    endcase
  end

  // Grant-time capture of the winning request; inputs are ignored afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt_data  <= 1'b0;
      r_we        <= 1'b0;
      r_last_data <= 1'b0;
      r_mem_addr  <= 9'd0;
      r_mem_wdata <= 32'd0;
      r_f_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      if (r_state == c_S_IDLE && w_any_req) begin
        r_gnt_data  <= w_pick_data;
        r_last_data <= w_pick_data;
        r_we        <= w_pick_data & d_we;
        r_mem_addr  <= w_pick_data ? d_addr : f_addr;
        if (w_pick_data) begin
          r_mem_wdata <= d_wdata;
        end
      end
      if (r_state == c_S_WAIT) begin
        if (r_gnt_data) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_f_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_read  = w_mem_read;
  assign mem_write = w_mem_write;
  assign f_ack     = w_f_ack;
  assign d_ack     = w_d_ack;
  assign busy      = w_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign f_rdata   = r_f_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Ports SHALL be exactly as follows, with clock and reset first:
  clock  in  1  single system clock; all state changes on its rising edge.
  reset  in  1  synchronous, active-high reset.
  f_req  in  1  fetch-port read request, level.
  f_addr  in  9  fetch word address.
  f_ack  out  1  one-cycle pulse; f_rdata valid.
  f_rdata  out  32  fetch read data, held until the next fetch completion.
  d_req  in  1  data-port request, level.
  d_we  in  1  data-port request type; 1 = write, 0 = read.
  d_addr  in  9  data word address.
  d_wdata  in  32  data-port write data.
  d_ack  out  1  one-cycle pulse; access complete.
  d_rdata  out  32  data-port read data, held until the next data read completion.
  mem_addr  out  9  memory address.
  mem_wdata  out  32  memory write data.
  mem_read  out  1  memory read strobe.
  mem_write  out  1  memory write strobe.
  mem_rdata  in  32  memory read data, valid the cycle after mem_read.
  busy  out  1  high when state is not IDLE.
REQ-002 There SHALL be one clock domain; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL share one single-port 512x32 memory between a fetch requester (read-only) and a data requester (read/write).
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and ACK, with these transitions:
  IDLE -> ISSUE on any request.
  ISSUE -> WAIT for a read.
  ISSUE -> ACK for a write.
  WAIT -> ACK unconditionally.
  ACK -> IDLE unconditionally.
REQ-005 In IDLE with exactly one request pending, that port SHALL be granted.
REQ-006 In IDLE with both requests pending, the port not granted last SHALL be granted (round-robin).
REQ-007 The last-grant register SHALL reset to "fetch", so the first tie after reset goes to the data port.
REQ-008 On grant, the arbiter SHALL latch the port, the address, and (for the data port) d_we and d_wdata.
REQ-009 mem_addr and mem_wdata SHALL be driven from the latched registers.
REQ-010 Requester inputs SHALL be ignored after the grant cycle.
REQ-011 mem_read (read) or mem_write (write) SHALL be high only in ISSUE, for exactly one cycle.
REQ-012 Both strobes SHALL never be high together.
REQ-013 A fetch grant SHALL always be a read, regardless of d_we.
REQ-014 In WAIT, mem_rdata SHALL be captured into f_rdata or d_rdata of the granted port, at the end of that cycle.
REQ-015 The other port's rdata SHALL remain unchanged.
REQ-016 In ACK, only the granted port's ack SHALL be high, for exactly one cycle.
REQ-017 Read latency SHALL be three cycles: a request sampled in IDLE at cycle T gives ack at T+3.
REQ-018 Write latency SHALL be two cycles: a request sampled in IDLE at cycle T gives ack at T+2.
REQ-019 A requester SHALL drop req in the cycle after its ack.
REQ-020 A req still high in that cycle SHALL be treated as a new request (back-to-back access), not an error.
REQ-021 A request raised while busy SHALL stay pending and SHALL be evaluated in the next IDLE; no request is lost.
REQ-022 There SHALL be no idle gap beyond the single IDLE arbitration cycle.
REQ-023 Address arithmetic SHALL NOT occur; addresses pass through unmodified, 9 bits, with no wrap logic.

Reset
REQ-024 When reset is high at a clock edge, the following SHALL take effect from the next cycle:
  state = IDLE.
  f_ack, d_ack, mem_read, mem_write, busy = 0.
  f_rdata, d_rdata, mem_addr, mem_wdata = 0.
  last-grant = fetch.
REQ-025 Reset SHALL take priority over every transition, including mid-operation (ISSUE, WAIT or ACK).
REQ-026 An aborted access SHALL produce no ack and no further strobes.

Verification
REQ-027 Fetch read: mem[0x005]=0x12345678; f_req at T -> mem_read=1 and mem_addr=0x005 at T+1; f_ack=1 and f_rdata=0x12345678 at T+3, for one cycle only.
REQ-028 Data write then fetch: d_req, d_we=1, d_addr=0x0A0, d_wdata=0xDEADBEEF -> mem_write for one cycle at T+1 and d_ack at T+2; a following fetch of 0x0A0 -> f_rdata=0xDEADBEEF.
REQ-029 Ties after reset: f_req and d_req both held continuously -> grant order data, fetch, data, fetch; acks strictly alternate and never overlap.
REQ-030 Request while busy: f_req raised during a data read's WAIT -> fetch ISSUE occurs one cycle after the data ACK (through IDLE); d_rdata is unchanged by the fetch.
REQ-031 Reset mid-write: reset asserted in the ISSUE cycle of a write -> next cycle mem_write=0, busy=0, no d_ack, all outputs zero.
REQ-032 Back-to-back fetch: f_req held across f_ack with the address changed 0x001 -> 0x002 -> second read issues to 0x002, and f_ack returns exactly 4 cycles after the first.
